// File: rtl/elastic_fifo.sv
// Elastic valid/ready buffer of DEPTH entries with occupancy and almost-full reporting.
// Optional zero-latency pass-through when empty is enabled by defining ELASTIC_FIFO_BYPASS_EN.
module elastic_fifo #(
    parameter int DWIDTH       = 8,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [DWIDTH-1:0]        i_data,
    input  logic                     i_data_valid,
    output logic                     o_data_ready,
    output logic [DWIDTH-1:0]        o_data,
    output logic                     o_data_valid,
    input  logic                     i_data_ready,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] LVL_AF   = (AW+1)'(AFULL_THRESH);

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, level, level_next;
    logic              ready_q, af_q;
    logic              push, wr_en, rd_en, stored;

    // Pointer difference is exact thanks to the wrap bit: 0..DEPTH.
    assign level  = wr_ptr - rd_ptr;
    assign stored = (level != '0);
    assign push   = i_data_valid & ready_q;
    assign rd_en  = stored & i_data_ready;

`ifdef ELASTIC_FIFO_BYPASS_EN
    logic thru;
    // A word arriving into an empty buffer with downstream ready skips storage.
    assign thru         = ~stored & push & i_data_ready;
    assign wr_en        = push & ~thru;
    assign o_data_valid = stored | push;
    assign o_data       = stored ? mem[rd_ptr[AW-1:0]] : (push ? i_data : '0);
`else
    assign wr_en        = push;
    assign o_data_valid = stored;
    assign o_data       = stored ? mem[rd_ptr[AW-1:0]] : '0;
`endif

    always_comb begin
        level_next = level;
        case ({wr_en, rd_en})
            2'b10:   level_next = level + ONE;
            2'b01:   level_next = level - ONE;
            default: level_next = level;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ready_q <= 1'b0;
            af_q    <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ONE;
            if (rd_en) rd_ptr <= rd_ptr + ONE;
            // Ready looks only at the next level, so a pop never frees a slot in the same cycle.
            ready_q <= (level_next < LVL_FULL);
            af_q    <= (level_next >= LVL_AF);
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= i_data;
    end

    assign o_data_ready  = ready_q;
    assign o_level       = level;
    assign o_almost_full = af_q;

endmodule

// File: tb/tb_elastic_fifo.sv
// Self-checking bench for elastic_fifo: directed vector table, corner sequences, and
// randomized traffic against a queue-based reference model.
module tb_elastic_fifo;

    localparam int DW     = 8;
    localparam int DEPTH  = 4;
    localparam int THRESH = 3;

    logic          i_clock = 1'b0;
    logic          i_reset_n;
    logic [DW-1:0] i_data;
    logic          i_data_valid;
    logic          o_data_ready;
    logic [DW-1:0] o_data;
    logic          o_data_valid;
    logic          i_data_ready;
    logic [2:0]    o_level;
    logic          o_almost_full;

    int tests = 0;
    int fails = 0;

    elastic_fifo #(.DWIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(THRESH)) dut (
        .i_clock(i_clock), .i_reset_n(i_reset_n),
        .i_data(i_data), .i_data_valid(i_data_valid), .o_data_ready(o_data_ready),
        .o_data(o_data), .o_data_valid(o_data_valid), .i_data_ready(i_data_ready),
        .o_level(o_level), .o_almost_full(o_almost_full)
    );

    always #5 i_clock = ~i_clock;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic [2:0]    lvl;
        logic          ov;
        logic [DW-1:0] od;
        logic          ordy;
        logic          af;
    } vec_t;

    vec_t tbl[9];
    logic [DW-1:0] q[$];
    logic          mrdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        i_data_valid = v;
        i_data       = d;
        i_data_ready = r;
    endtask

    task automatic chk_all(input string tag, input logic [2:0] lvl, input logic ov,
                           input logic [DW-1:0] od, input logic ordy, input logic af);
        chk({tag, ".level"}, 32'(o_level), 32'(lvl));
        chk({tag, ".valid"}, 32'(o_data_valid), 32'(ov));
        chk({tag, ".data"},  32'(o_data), 32'(od));
        chk({tag, ".ready"}, 32'(o_data_ready), 32'(ordy));
        chk({tag, ".afull"}, 32'(o_almost_full), 32'(af));
    endtask

    initial begin
        // Fill with downstream stalled, try a 5th word, then drain.
        tbl[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1, 1'b1};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 3'd3, 1'b1, 8'h22, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h44, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};

        // Reset with upstream valid held high.
        i_reset_n = 1'b0;
        drive(1'b1, 8'h99, 1'b0);
        #1;
        chk_all("rst_async", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        chk_all("rst_held", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        i_reset_n = 1'b1;
        #1;
        chk("rst_release.ready", 32'(o_data_ready), 32'd0);
        tick();
        chk_all("rst_first_edge", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v, tbl[i].d, tbl[i].r);
            tick();
            chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].ov, tbl[i].od, tbl[i].ordy, tbl[i].af);
        end

        // Streaming across pointer wrap at constant level 1.
        drive(1'b1, 8'h40, 1'b0);
        tick();
        chk("stream_prime.level", 32'(o_level), 32'd1);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 8'(8'h41 + k), 1'b1);
            #1;
            chk($sformatf("stream%0d.pre_data", k), 32'(o_data), 32'(8'(8'h40 + k)));
            tick();
            chk($sformatf("stream%0d.level", k), 32'(o_level), 32'd1);
            chk($sformatf("stream%0d.data", k), 32'(o_data), 32'(8'(8'h41 + k)));
            chk($sformatf("stream%0d.ready", k), 32'(o_data_ready), 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1);
        tick();
        chk_all("stream_end", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Full plus pop: push refused that cycle, accepted the next.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'(8'hC0 + k), 1'b0);
            tick();
        end
        chk_all("fp_full", 3'd4, 1'b1, 8'hC0, 1'b0, 1'b1);
        drive(1'b1, 8'hC4, 1'b1);
        tick();
        chk_all("fp_pop", 3'd3, 1'b1, 8'hC1, 1'b1, 1'b1);
        drive(1'b1, 8'hC4, 1'b0);
        tick();
        chk_all("fp_push", 3'd4, 1'b1, 8'hC1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 8'h00, 1'b1);
            #1;
            chk($sformatf("fp_drain%0d", k), 32'(o_data), 32'(8'(8'hC1 + k)));
            tick();
        end
        chk_all("fp_empty", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        // Push into empty buffer with downstream ready.
        drive(1'b1, 8'hA5, 1'b1);
        #1;
`ifdef ELASTIC_FIFO_BYPASS_EN
        chk("byp_same.valid", 32'(o_data_valid), 32'd1);
        chk("byp_same.data", 32'(o_data), 32'hA5);
`else
        chk("byp_same.valid", 32'(o_data_valid), 32'd0);
        chk("byp_same.data", 32'(o_data), 32'h00);
`endif
        tick();
        drive(1'b0, 8'h00, 1'b0);
        #1;
`ifdef ELASTIC_FIFO_BYPASS_EN
        chk_all("byp_next", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);
`else
        chk_all("byp_next", 3'd1, 1'b1, 8'hA5, 1'b1, 1'b0);
`endif
        drive(1'b0, 8'h00, 1'b1);
        tick();
        chk("byp_clear.level", 32'(o_level), 32'd0);

        // Randomized traffic against a queue model.
        q.delete();
        mrdy = 1'b1;
        for (int c = 0; c < 400; c++) begin
            logic v, r, push, pop, thru;
            logic [DW-1:0] d, exp_d;
            logic exp_v;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            if (c % 64 >= 48) r = 1'b0;
            d = 8'($urandom);
            drive(v, d, r);
            #1;
            push = v & mrdy;
            thru = 1'b0;
`ifdef ELASTIC_FIFO_BYPASS_EN
            thru = (q.size() == 0) & push & r;
`endif
            exp_v = (q.size() != 0);
            exp_d = (q.size() != 0) ? q[0] : 8'h00;
`ifdef ELASTIC_FIFO_BYPASS_EN
            if (q.size() == 0 && push) begin
                exp_v = 1'b1;
                exp_d = d;
            end
`endif
            chk("rand.valid", 32'(o_data_valid), 32'(exp_v));
            chk("rand.data", 32'(o_data), 32'(exp_d));
            chk("rand.level", 32'(o_level), 32'(q.size()));
            chk("rand.ready", 32'(o_data_ready), 32'(mrdy));
            chk("rand.afull", 32'(o_almost_full), 32'(q.size() >= THRESH));
            pop = (q.size() != 0) & r;
            tick();
            if (pop) void'(q.pop_front());
            if (push && !thru) q.push_back(d);
            mrdy = (q.size() < DEPTH);
        end

        // Asynchronous reset with data in flight.
        drive(1'b1, 8'h77, 1'b0);
        tick();
        tick();
        i_reset_n = 1'b0;
        #1;
        chk_all("rst_mid", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0);
        i_reset_n = 1'b1;
        tick();
        chk_all("rst_mid_after", 3'd0, 1'b0, 8'h00, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
